// File: rtl/m_axil_cmd_master.sv
// AXI4-Lite initiator: converts single-beat commands into AXI4-Lite reads/writes,
// one transaction outstanding, and returns each result on a response port.
module m_axil_cmd_master #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 40,
  parameter logic [2:0]  PROT       = 3'b000
) (
  input  logic                      axi_clock,
  input  logic                      rst,
  // command port
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  // response port
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_write,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      busy,
  // AXI4-Lite master
  output logic [ADDR_WIDTH-1:0]     m_axil_awaddr,
  output logic [2:0]                m_axil_awprot,
  output logic                      m_axil_awvalid,
  input  logic                      m_axil_awready,
  output logic [DATA_WIDTH-1:0]     m_axil_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axil_wstrb,
  output logic                      m_axil_wvalid,
  input  logic                      m_axil_wready,
  input  logic [1:0]                m_axil_bresp,
  input  logic                      m_axil_bvalid,
  output logic                      m_axil_bready,
  output logic [ADDR_WIDTH-1:0]     m_axil_araddr,
  output logic [2:0]                m_axil_arprot,
  output logic                      m_axil_arvalid,
  input  logic                      m_axil_arready,
  input  logic [DATA_WIDTH-1:0]     m_axil_rdata,
  input  logic [1:0]                m_axil_rresp,
  input  logic                      m_axil_rvalid,
  output logic                      m_axil_rready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t                    state_q, state_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
  logic                      rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                rsp_resp_q, rsp_resp_d;

  always_ff @(posedge axi_clock) begin
    if (rst) begin
      state_q     <= IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  // AW and W retire independently; WR is left only once both have handshaken.
  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          awvalid_d = cmd_write;
          wvalid_d  = cmd_write;
          state_d   = cmd_write ? WR : RD_ADDR;
        end
      end
      WR: begin
        if (m_axil_awready) awvalid_d = 1'b0;
        if (m_axil_wready)  wvalid_d  = 1'b0;
        if ((!awvalid_q || m_axil_awready) && (!wvalid_q || m_axil_wready))
          state_d = WR_RESP;
      end
      WR_RESP: begin
        if (m_axil_bvalid) begin
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = m_axil_bresp;
          state_d     = RSP;
        end
      end
      RD_ADDR: begin
        if (m_axil_arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (m_axil_rvalid) begin
          rsp_write_d = 1'b0;
          rsp_rdata_d = m_axil_rdata;
          rsp_resp_d  = m_axil_rresp;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // All handshake outputs come straight from registers, never from a ready.
  always_comb begin
    cmd_ready      = (state_q == IDLE);
    busy           = (state_q != IDLE);
    rsp_valid      = (state_q == RSP);
    rsp_write      = rsp_write_q;
    rsp_rdata      = rsp_rdata_q;
    rsp_resp       = rsp_resp_q;
    m_axil_awaddr  = addr_q;
    m_axil_awprot  = PROT;
    m_axil_awvalid = awvalid_q;
    m_axil_wdata   = wdata_q;
    m_axil_wstrb   = wstrb_q;
    m_axil_wvalid  = wvalid_q;
    m_axil_bready  = (state_q == WR_RESP);
    m_axil_araddr  = addr_q;
    m_axil_arprot  = PROT;
    m_axil_arvalid = (state_q == RD_ADDR);
    m_axil_rready  = (state_q == RD_DATA);
  end

endmodule

// File: tb/tb_m_axil_cmd_master.sv
// Directed + random bench for m_axil_cmd_master with a stall-configurable
// AXI4-Lite slave, a response scoreboard and a protocol watcher.
module tb_m_axil_cmd_master;
  localparam int DW = 32;
  localparam int AW = 40;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          busy;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic [1:0]    bresp, rresp;

  m_axil_cmd_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PROT(3'b000)) dut (
    .axi_clock(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
    .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
    .m_axil_awready(awready), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
    .m_axil_wvalid(wvalid), .m_axil_wready(wready), .m_axil_bresp(bresp),
    .m_axil_bvalid(bvalid), .m_axil_bready(bready), .m_axil_araddr(araddr),
    .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
    .m_axil_rready(rready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- slave model ----------------
  int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic aw_have, w_have, ar_have;
  int aw_cnt, w_cnt, bw_cnt, ar_cnt, r_cnt;
  int b_count = 0;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [DW-1:0] s_wdata;
  logic [SW-1:0] s_wstrb;
  logic [DW-1:0] mem [logic [AW-1:0]];

  always @(posedge clk) begin
    logic [DW-1:0] cur;
    if (rst) begin
      awready <= 0; wready <= 0; bvalid <= 0; arready <= 0; rvalid <= 0;
      rdata <= '0; rresp <= 0; bresp <= 0;
      aw_have <= 0; w_have <= 0; ar_have <= 0;
      aw_cnt <= 0; w_cnt <= 0; bw_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
    end else begin
      if (awvalid && awready) begin
        awready <= 0; aw_have <= 1; s_awaddr <= awaddr; aw_cnt <= 0;
      end else if (awvalid && !aw_have) begin
        if (aw_cnt >= aw_wait) awready <= 1; else aw_cnt <= aw_cnt + 1;
      end
      if (wvalid && wready) begin
        wready <= 0; w_have <= 1; s_wdata <= wdata; s_wstrb <= wstrb; w_cnt <= 0;
      end else if (wvalid && !w_have) begin
        if (w_cnt >= w_wait) wready <= 1; else w_cnt <= w_cnt + 1;
      end
      if (bvalid && bready) begin
        bvalid <= 0; aw_have <= 0; w_have <= 0; bw_cnt <= 0; b_count <= b_count + 1;
      end else if (aw_have && w_have && !bvalid) begin
        if (bw_cnt >= b_wait) begin
          cur = mem.exists(s_awaddr) ? mem[s_awaddr] : '0;
          for (int i = 0; i < SW; i++) if (s_wstrb[i]) cur[8*i +: 8] = s_wdata[8*i +: 8];
          mem[s_awaddr] = cur;
          bvalid <= 1; bresp <= bresp_cfg;
        end else bw_cnt <= bw_cnt + 1;
      end
      if (arvalid && arready) begin
        arready <= 0; ar_have <= 1; s_araddr <= araddr; ar_cnt <= 0;
      end else if (arvalid && !ar_have) begin
        if (ar_cnt >= ar_wait) arready <= 1; else ar_cnt <= ar_cnt + 1;
      end
      if (rvalid && rready) begin
        rvalid <= 0; ar_have <= 0; r_cnt <= 0;
      end else if (ar_have && !rvalid) begin
        if (r_cnt >= r_wait) begin
          rvalid <= 1;
          rdata <= mem.exists(s_araddr) ? mem[s_araddr] : '0;
          rresp <= rresp_cfg;
        end else r_cnt <= r_cnt + 1;
      end
    end
  end

  // ---------------- protocol watcher ----------------
  int viol = 0;
  logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
  logic [AW-1:0] p_awa, p_ara;
  logic [DW-1:0] p_wd;
  logic [SW-1:0] p_ws;
  always @(posedge clk) begin
    if (rst) begin
      p_awv <= 0; p_wv <= 0; p_arv <= 0; p_awr <= 0; p_wr <= 0; p_arr <= 0;
    end else begin
      if (p_awv && !p_awr && (!awvalid || awaddr != p_awa)) viol <= viol + 1;
      if (p_wv && !p_wr && (!wvalid || wdata != p_wd || wstrb != p_ws)) viol <= viol + 1;
      if (p_arv && !p_arr && (!arvalid || araddr != p_ara)) viol <= viol + 1;
      if ((bready && rready) || (busy == cmd_ready)) viol <= viol + 1;
      if ((awvalid || wvalid) && (arvalid || rready)) viol <= viol + 1;
      p_awv <= awvalid; p_awr <= awready; p_awa <= awaddr;
      p_wv <= wvalid; p_wr <= wready; p_wd <= wdata; p_ws <= wstrb;
      p_arv <= arvalid; p_arr <= arready; p_ara <= araddr;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct { logic w; logic [DW-1:0] d; logic [1:0] r; } exp_t;
  exp_t sb_q[$];
  logic [DW-1:0] model [logic [AW-1:0]];

  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) check("rsp_unexpected", 64'd1, 64'd0);
      else begin
        e = sb_q.pop_front();
        check("rsp_write", {63'd0, rsp_write}, {63'd0, e.w});
        check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.d});
        check("rsp_resp", {62'd0, rsp_resp}, {62'd0, e.r});
      end
    end
  end

  task automatic do_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input logic [1:0] er);
    exp_t e;
    logic [DW-1:0] cur;
    bit ok = 0;
    cur = model.exists(a) ? model[a] : '0;
    if (w) begin
      for (int i = 0; i < SW; i++) if (s[i]) cur[8*i +: 8] = d[8*i +: 8];
      model[a] = cur;
      e.d = '0;
    end else e.d = cur;
    e.w = w; e.r = er;
    sb_q.push_back(e);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk); #1;
        ok = 1;
        break;
      end
    end
    cmd_valid = 0;
    if (!ok) begin
      check("cmd_accept_timeout", 64'd1, 64'd0);
      void'(sb_q.pop_back());
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && cmd_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      check("rsp_timeout", 64'd1, 64'd0);
      sb_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout observed running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] snap_d;
    logic [1:0] snap_r;
    logic snap_w;
    int b_before;
    bit ok;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic [SW-1:0] rs;

    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; rsp_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valids", {60'd0, awvalid, wvalid, arvalid, rsp_valid}, 64'd0);
    check("reset_readies", {62'd0, bready, rready}, 64'd0);
    check("reset_rsp", {29'd0, rsp_write, rsp_resp, rsp_rdata}, 64'd0);
    check("reset_cmd_ready", {62'd0, cmd_ready, busy}, 64'd2);
    check("reset_addr", {24'd0, awaddr}, 64'd0);
    @(posedge clk); #1; rst = 0;
    @(posedge clk); #1;

    // 1: zero-wait write
    do_cmd(1, 40'h4, 32'hDEADBEEF, 4'hF, 2'b00);
    @(negedge clk);
    check("t1_aw_w_valid", {62'd0, awvalid, wvalid}, 64'd3);
    check("t1_awaddr", {24'd0, awaddr}, 64'h4);
    check("t1_wdata", {28'd0, wstrb, wdata}, {28'd0, 4'hF, 32'hDEADBEEF});
    wait_idle();
    check("t1_slave_mem", {32'd0, mem.exists(40'h4) ? mem[40'h4] : 32'h0}, 64'hDEADBEEF);

    // 2: AW accepted 3 cycles ahead of W
    aw_wait = 0; w_wait = 3; b_before = b_count;
    do_cmd(1, 40'h8, 32'h12345678, 4'hF, 2'b00);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (aw_have) begin ok = 1; break; end
    end
    check("t2_aw_seen", {63'd0, ok}, 64'd1);
    check("t2_aw_drop_w_hold", {62'd0, awvalid, wvalid}, 64'd1);
    wait_idle();
    check("t2_one_b", b_count - b_before, 64'd1);
    w_wait = 0;

    // 3: read back, then a slave error response
    do_cmd(0, 40'h4, 32'h0, 4'h0, 2'b00);
    wait_idle();
    rresp_cfg = 2'b10;
    do_cmd(0, 40'h4, 32'h0, 4'h0, 2'b10);
    wait_idle();
    rresp_cfg = 2'b00;

    // 4: response backpressure
    rsp_ready = 0;
    do_cmd(0, 40'h8, 32'h0, 4'h0, 2'b00);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1; break; end
    end
    check("t4_rsp_seen", {63'd0, ok}, 64'd1);
    snap_d = rsp_rdata; snap_r = rsp_resp; snap_w = rsp_write;
    check("t4_rsp_data", {32'd0, snap_d}, 64'h12345678);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold", {28'd0, rsp_valid, cmd_ready, awvalid | wvalid | arvalid, rsp_write, rsp_resp, rsp_rdata},
            {28'd0, 1'b1, 1'b0, 1'b0, snap_w, snap_r, snap_d});
    end
    @(posedge clk); #1; rsp_ready = 1;
    wait_idle();
    do_cmd(1, 40'hC, 32'hA5A5A5A5, 4'hF, 2'b00);
    wait_idle();

    // 5: reset while waiting for B
    b_wait = 10;
    do_cmd(1, 40'h100, 32'h55AA55AA, 4'hF, 2'b00);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bready) begin ok = 1; break; end
    end
    check("t5_in_wr_resp", {63'd0, ok}, 64'd1);
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1;
    sb_q.delete();
    @(negedge clk);
    check("t5_after_rst", {57'd0, awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready}, 64'd1);
    @(posedge clk); #1; rst = 0; b_wait = 0;
    @(posedge clk); #1;

    // 6: random write/read pairs with random slave stalls
    for (int k = 0; k < 16; k++) begin
      ra = 40'h200 + 40'($urandom_range(0, 7) * 4);
      rd = $urandom;
      rs = 4'($urandom_range(1, 15));
      aw_wait = $urandom_range(0, 3); w_wait = $urandom_range(0, 3);
      b_wait = $urandom_range(0, 3); ar_wait = $urandom_range(0, 3);
      r_wait = $urandom_range(0, 3);
      do_cmd(1, ra, rd, rs, 2'b00);
      do_cmd(0, ra, 32'h0, 4'h0, 2'b00);
    end
    wait_idle();

    check("proto_violations", viol, 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
